// File: rtl/axis_crc32_pkg.sv
// Shared CRC32/MPEG-2 definitions for the AXI-Stream generator and checker.
package axis_crc32_pkg;

   typedef logic [31:0] crc32_t;

   localparam crc32_t CRC32_MPEG2_POLY = 32'h04C1_1DB7;
   localparam crc32_t CRC32_MPEG2_INIT = 32'hFFFF_FFFF;

   typedef enum logic {S_DATA, S_CRC} chk_state_e;

   // One 32-bit word through the MSB-first, non-reflected CRC register:
   // fold the word in, then 32 serial shifts with conditional polynomial XOR.
   function automatic crc32_t crc32_mpeg2_next(input crc32_t crc, input crc32_t data,
                                               input crc32_t poly);
      crc32_t c;
      c = crc ^ data;
      for (int i = 0; i < 32; i++)
         c = c[31] ? ((c << 1) ^ poly) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/axis_crc32_mpeg2_checker.sv
// AXI-Stream CRC32/MPEG-2 frame checker: forwards FRAME_WORDS data words per
// frame through one output register, strips the trailing CRC word, and
// reports a per-frame pass/fail pulse plus running frame/error counters.
module axis_crc32_mpeg2_checker
   import axis_crc32_pkg::*;
#(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter logic [31:0] POLY_CRC       = CRC32_MPEG2_POLY,
   parameter logic [31:0] INIT_CRC       = CRC32_MPEG2_INIT,
   parameter int          FRAME_WORDS    = 16,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic                      crc_valid,
   output logic                      crc_ok,
   output logic [CNT_WIDTH-1:0]      frame_cnt,
   output logic [CNT_WIDTH-1:0]      err_cnt
);

   generate
      if (AXI_DATA_WIDTH != 32) begin : g_bad_width
         $error("axis_crc32_mpeg2_checker: AXI_DATA_WIDTH must be 32");
      end
      if (FRAME_WORDS < 1 || FRAME_WORDS > 65535) begin : g_bad_frame
         $error("axis_crc32_mpeg2_checker: FRAME_WORDS must be in 1..65535");
      end
   endgenerate

   localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

   chk_state_e  state, state_nxt;
   logic [15:0] word_cnt;
   crc32_t      crc_q;
   crc32_t      crc_nxt;
   logic        accept;
   logic        last_word;

   // Handshake and CRC update for the word currently on the input.
   // Ready is gated by reset so every output reads 0 while in reset.
   always_comb begin
      s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready);
      accept        = s_axis_tvalid && s_axis_tready;
      last_word     = (word_cnt == LAST_IDX);
      crc_nxt       = crc32_mpeg2_next(crc_q, s_axis_tdata, POLY_CRC);
   end

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= S_DATA;
      else          state <= state_nxt;
   end

   // Next state: last data word moves to the trailer, trailer returns to data.
   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (state == S_DATA) begin
            if (last_word) state_nxt = S_CRC;
         end else begin
            state_nxt = S_DATA;
         end
      end
   end

   // Output register, word counter, CRC register and statistics.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         crc_valid     <= 1'b0;
         crc_ok        <= 1'b0;
         frame_cnt     <= '0;
         err_cnt       <= '0;
         word_cnt      <= '0;
         crc_q         <= INIT_CRC;
      end else begin
         crc_valid <= 1'b0;
         // drained beat; overridden below when a new data word is loaded
         if (m_axis_tready) m_axis_tvalid <= 1'b0;
         if (accept) begin
            if (state == S_DATA) begin
               m_axis_tdata  <= s_axis_tdata;
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= last_word;
               crc_q         <= crc_nxt;
               word_cnt      <= last_word ? 16'd0 : word_cnt + 16'd1;
            end else begin
               // trailer consumed: residue of data+trailer decides the frame
               crc_q     <= INIT_CRC;
               crc_valid <= 1'b1;
               crc_ok    <= (crc_nxt == '0);
               frame_cnt <= frame_cnt + 1'b1;
               if (crc_nxt != '0) err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_crc32_mpeg2_checker.sv
// Directed bench for axis_crc32_mpeg2_checker: a FRAME_WORDS=1 / 4-bit counter
// instance (table vectors, counter wrap) and a FRAME_WORDS=4 instance
// (back-to-back, mid-frame reset, random backpressure).
module tb_axis_crc32_mpeg2_checker;

   localparam logic [31:0] POLY = 32'h04C1_1DB7;
   localparam logic [31:0] INIT = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic aresetn = 1'b1;
   always #5 clk = ~clk;

   // instance A: FRAME_WORDS=1, CNT_WIDTH=4
   logic [31:0] s_tdata_a = '0, m_tdata_a;
   logic        s_tvalid_a = 1'b0, s_tready_a, m_tvalid_a, tready_a = 1'b1, m_tlast_a;
   logic        crc_valid_a, crc_ok_a;
   logic [3:0]  frame_cnt_a, err_cnt_a;
   // instance B: FRAME_WORDS=4, CNT_WIDTH=16
   logic [31:0] s_tdata_b = '0, m_tdata_b;
   logic        s_tvalid_b = 1'b0, s_tready_b, m_tvalid_b, tready_b = 1'b1, m_tlast_b;
   logic        crc_valid_b, crc_ok_b;
   logic [15:0] frame_cnt_b, err_cnt_b;

   axis_crc32_mpeg2_checker #(.AXI_DATA_WIDTH(32), .POLY_CRC(POLY), .INIT_CRC(INIT),
                              .FRAME_WORDS(1), .CNT_WIDTH(4)) dut_a (
      .aclk(clk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata_a), .s_axis_tvalid(s_tvalid_a), .s_axis_tready(s_tready_a),
      .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(tready_a),
      .m_axis_tlast(m_tlast_a), .crc_valid(crc_valid_a), .crc_ok(crc_ok_a),
      .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a));

   axis_crc32_mpeg2_checker #(.AXI_DATA_WIDTH(32), .POLY_CRC(POLY), .INIT_CRC(INIT),
                              .FRAME_WORDS(4), .CNT_WIDTH(16)) dut_b (
      .aclk(clk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b), .s_axis_tready(s_tready_b),
      .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(tready_b),
      .m_axis_tlast(m_tlast_b), .crc_valid(crc_valid_b), .crc_ok(crc_ok_b),
      .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b));

   int n_cmp = 0;
   int n_bad = 0;

   logic [32:0] exp_a[$], exp_b[$];   // {tlast, tdata}
   bit          ok_a[$], ok_b[$];
   bit          acc_a, acc_b, rand_b = 1'b0, ignore_b = 1'b0;
   bit          prev_stall_b = 1'b0;
   logic [31:0] prev_data_b = '0;
   int          beats_b = 0, tlast_b = 0, pulses_b = 0;

   // Reference CRC: bit-at-a-time LFSR, data fed MSB first.
   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
      logic fb;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not expected / missing", name);
   endtask

   // One clock: sample and score outputs at negedge, then advance past posedge.
   task automatic tick();
      logic [32:0] e;
      @(negedge clk);
      acc_a = s_tvalid_a && s_tready_a;
      acc_b = s_tvalid_b && s_tready_b;
      if (aresetn) begin
         if (m_tvalid_a && tready_a) begin
            if (exp_a.size() == 0) fail_now("a_extra_beat");
            else begin
               e = exp_a.pop_front();
               chk("a_tdata", m_tdata_a, e[31:0]);
               chk("a_tlast", {31'd0, m_tlast_a}, {31'd0, e[32]});
            end
         end
         if (crc_valid_a) begin
            if (ok_a.size() == 0) fail_now("a_extra_crc_valid");
            else chk("a_crc_ok", {31'd0, crc_ok_a}, {31'd0, ok_a.pop_front()});
         end
         if (prev_stall_b) begin
            chk("b_hold_tvalid", {31'd0, m_tvalid_b}, 32'd1);
            chk("b_hold_tdata", m_tdata_b, prev_data_b);
         end
         prev_stall_b = m_tvalid_b && !tready_b;
         prev_data_b  = m_tdata_b;
         if (m_tvalid_b && tready_b && !ignore_b) begin
            beats_b++;
            if (m_tlast_b) tlast_b++;
            if (exp_b.size() == 0) fail_now("b_extra_beat");
            else begin
               e = exp_b.pop_front();
               chk("b_tdata", m_tdata_b, e[31:0]);
               chk("b_tlast", {31'd0, m_tlast_b}, {31'd0, e[32]});
            end
         end
         if (crc_valid_b) begin
            pulses_b++;
            if (ok_b.size() == 0) fail_now("b_extra_crc_valid");
            else chk("b_crc_ok", {31'd0, crc_ok_b}, {31'd0, ok_b.pop_front()});
         end
      end
      @(posedge clk);
      #1;
      if (rand_b) tready_b = ($urandom_range(0, 1) == 1);
   endtask

   // Present one word to instance sel (0=A, 1=B) after an optional idle gap.
   task automatic send(input bit sel, input logic [31:0] w, input int gap, output int stalls);
      bit done;
      stalls = 0;
      done   = 1'b0;
      if (gap > 0) begin
         if (sel) s_tvalid_b = 1'b0; else s_tvalid_a = 1'b0;
         repeat (gap) tick();
      end
      if (sel) begin s_tdata_b = w; s_tvalid_b = 1'b1; end
      else     begin s_tdata_a = w; s_tvalid_a = 1'b1; end
      for (int k = 0; k < 200 && !done; k++) begin
         tick();
         if (sel ? acc_b : acc_a) done = 1'b1;
         else stalls++;
      end
      if (!done) fail_now("accept_timeout");
   endtask

   // Four-word frame into instance B with model trailer XOR flip.
   task automatic frame_b(input logic [31:0] flip, input int gapmax, output int stalls);
      logic [31:0] c, d;
      int st;
      c = INIT;
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         d = $urandom();
         c = ref_crc(c, d);
         exp_b.push_back({(i == 3), d});
         send(1'b1, d, (gapmax > 0) ? $urandom_range(0, gapmax) : 0, st);
         stalls += st;
      end
      ok_b.push_back(flip == 32'd0);
      send(1'b1, c ^ flip, (gapmax > 0) ? $urandom_range(0, gapmax) : 0, st);
      stalls += st;
   endtask

   task automatic do_reset(input bit check);
      aresetn    = 1'b0;
      s_tvalid_a = 1'b0;
      s_tvalid_b = 1'b0;
      rand_b     = 1'b0;
      tready_b   = 1'b1;
      @(negedge clk);
      if (check) begin
         chk("rst_a_tvalid", {31'd0, m_tvalid_a}, 32'd0);
         chk("rst_a_tdata", m_tdata_a, 32'd0);
         chk("rst_a_tlast", {31'd0, m_tlast_a}, 32'd0);
         chk("rst_a_crc", {30'd0, crc_valid_a, crc_ok_a}, 32'd0);
         chk("rst_a_cnts", {24'd0, frame_cnt_a, err_cnt_a}, 32'd0);
         chk("rst_a_sready", {31'd0, s_tready_a}, 32'd0);
         chk("rst_b_tvalid", {31'd0, m_tvalid_b}, 32'd0);
         chk("rst_b_tdata", m_tdata_b, 32'd0);
         chk("rst_b_crc", {29'd0, m_tlast_b, crc_valid_b, crc_ok_b}, 32'd0);
         chk("rst_b_cnts", {frame_cnt_b, err_cnt_b}, 32'd0);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_a.delete(); exp_b.delete(); ok_a.delete(); ok_b.delete();
      prev_stall_b = 1'b0;
      beats_b = 0; tlast_b = 0; pulses_b = 0;
      aresetn = 1'b1;
   endtask

   typedef struct {
      logic [31:0] data;
      logic [31:0] trailer;
      bit          use_model;
      logic [31:0] flip;
      bit          exp_ok;
   } vec_t;

   initial begin
      vec_t vt[6];
      logic [31:0] trl;
      int st, tot, ef, ee;

      vt[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0, 1'b1};
      vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b0};
      vt[2] = '{32'h0000_0000, 32'h0,         1'b1, 32'h0, 1'b1};
      vt[3] = '{32'h1234_5678, 32'h0,         1'b1, 32'h0, 1'b1};
      vt[4] = '{32'hDEAD_BEEF, 32'h0,         1'b1, 32'h8000_0000, 1'b0};
      vt[5] = '{32'hC0FF_EE00, 32'h0,         1'b1, 32'h0, 1'b1};

      #2;
      do_reset(1'b1);

      // FRAME_WORDS=1 table: forward data with tlast, check, counters
      ef = 0; ee = 0;
      for (int i = 0; i < 6; i++) begin
         trl = vt[i].use_model ? (ref_crc(INIT, vt[i].data) ^ vt[i].flip) : vt[i].trailer;
         exp_a.push_back({1'b1, vt[i].data});
         ok_a.push_back(vt[i].exp_ok);
         send(1'b0, vt[i].data, 0, st);
         send(1'b0, trl, 0, st);
         s_tvalid_a = 1'b0;
         tick(); tick();
         ef++;
         if (!vt[i].exp_ok) ee++;
         chk("a_frame_cnt", {28'd0, frame_cnt_a}, 32'(ef));
         chk("a_err_cnt", {28'd0, err_cnt_a}, 32'(ee));
      end
      chk("a_pending_beats", 32'(exp_a.size()), 32'd0);
      chk("a_pending_checks", 32'(ok_a.size()), 32'd0);

      // 4-bit counter wrap: 17 good frames leaves frame_cnt at 1
      do_reset(1'b0);
      for (int i = 0; i < 17; i++) begin
         exp_a.push_back({1'b1, 32'(i * 32'h0101_0101)});
         ok_a.push_back(1'b1);
         send(1'b0, 32'(i * 32'h0101_0101), 0, st);
         send(1'b0, ref_crc(INIT, 32'(i * 32'h0101_0101)), 0, st);
      end
      s_tvalid_a = 1'b0;
      tick(); tick();
      chk("a_wrap_frame_cnt", {28'd0, frame_cnt_a}, 32'd1);
      chk("a_wrap_err_cnt", {28'd0, err_cnt_a}, 32'd0);

      // FRAME_WORDS=4: 8 back-to-back frames, frame 3 corrupted, no bubbles
      do_reset(1'b0);
      tot = 0;
      for (int f = 0; f < 8; f++) begin
         frame_b((f == 3) ? 32'h0000_0100 : 32'h0, 0, st);
         tot += st;
      end
      s_tvalid_b = 1'b0;
      repeat (3) tick();
      chk("b2b_input_stalls", 32'(tot), 32'd0);
      chk("b2b_beats", 32'(beats_b), 32'd32);
      chk("b2b_tlasts", 32'(tlast_b), 32'd8);
      chk("b2b_pulses", 32'(pulses_b), 32'd8);
      chk("b2b_frame_cnt", {16'd0, frame_cnt_b}, 32'd8);
      chk("b2b_err_cnt", {16'd0, err_cnt_b}, 32'd1);

      // reset after 2 of 4 words, then a clean frame
      do_reset(1'b0);
      ignore_b = 1'b1;
      send(1'b1, 32'hAAAA_0001, 0, st);
      send(1'b1, 32'hAAAA_0002, 0, st);
      do_reset(1'b1);
      ignore_b = 1'b0;
      frame_b(32'h0, 0, st);
      s_tvalid_b = 1'b0;
      repeat (3) tick();
      chk("mid_rst_pulses", 32'(pulses_b), 32'd1);
      chk("mid_rst_frame_cnt", {16'd0, frame_cnt_b}, 32'd1);
      chk("mid_rst_err_cnt", {16'd0, err_cnt_b}, 32'd0);

      // random backpressure and upstream gaps over 100 frames
      do_reset(1'b0);
      rand_b = 1'b1;
      for (int f = 0; f < 100; f++) frame_b(32'h0, 2, st);
      s_tvalid_b = 1'b0;
      rand_b = 1'b0;
      tready_b = 1'b1;
      repeat (5) tick();
      chk("rnd_pending_beats", 32'(exp_b.size()), 32'd0);
      chk("rnd_pending_checks", 32'(ok_b.size()), 32'd0);
      chk("rnd_beats", 32'(beats_b), 32'd400);
      chk("rnd_frame_cnt", {16'd0, frame_cnt_b}, 32'd100);
      chk("rnd_err_cnt", {16'd0, err_cnt_b}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_crc32_mpeg2_checker.md
Name: axis_crc32_mpeg2_checker

Overview:
- Downstream stage of the AXI-Stream CRC32/MPEG-2 generator. It consumes fixed-length frames of FRAME_WORDS data words, each followed by one CRC trailer word.
- Forwards the data words with tlast marking the frame end, and strips the CRC word.
- Recomputes CRC32/MPEG-2 over data plus trailer and reports pass/fail per frame, with running frame and error counters.
- Sits between the CRC-protected link and the consumer logic.

Parameters:
- AXI_DATA_WIDTH, 32: stream width. Only 32 is legal; any other value is a compile-time error.
- POLY_CRC, 32'h04C1_1DB7: generator polynomial.
- INIT_CRC, 32'hFFFF_FFFF: CRC register value at the start of each frame.
- FRAME_WORDS, 16: data words per frame, range 1..65535.
- CNT_WIDTH, 16: width of the statistic counters.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  AXI_DATA_WIDTH  incoming data words, then the CRC word.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  ready to upstream.
- m_axis_tdata  out  AXI_DATA_WIDTH  forwarded data word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the last data word of a frame.
- crc_valid  out  1  one-cycle pulse when a frame's check completes.
- crc_ok  out  1  check result; valid only while crc_valid is high.
- frame_cnt  out  CNT_WIDTH  number of frames checked.
- err_cnt  out  CNT_WIDTH  number of frames that failed.

Behaviour:
- Reset (aresetn low, asynchronous): all outputs 0. State is S_DATA, word counter is 0, CRC register is INIT_CRC, output register is empty.
- CRC algorithm (MPEG-2): non-reflected, MSB-first, no final XOR. Each word updates the register as 32 serial shifts of (crc XOR data). A correct frame, taken as data plus trailer, leaves a residue of 32'h0000_0000. Pass condition: residue == 0.
- Handshake: one output register stage.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready in both states.
  - A word is accepted when s_axis_tvalid && s_axis_tready.
  - m_axis_tvalid clears when m_axis_tready is high and no new data word is loaded in the same cycle.
  - Output data is stable while tvalid && !tready.
- State S_DATA:
  - Each accepted word is loaded into the output register and updates the CRC. Latency is 1 cycle, input to m_axis.
  - m_axis_tlast = (counter == FRAME_WORDS-1) for the loaded word.
  - On acceptance at counter FRAME_WORDS-1: counter resets to 0 and the state moves to S_CRC. Otherwise the counter increments.
- State S_CRC:
  - The accepted word updates the CRC and is not forwarded.
  - Next cycle: crc_valid=1 and crc_ok=(residue==0). frame_cnt increments; err_cnt increments if the check failed.
  - The CRC register reloads INIT_CRC and the state returns to S_DATA.
  - The next frame's first word may be accepted the cycle after the CRC word.
- Counters wrap modulo 2^CNT_WIDTH.
- Back-to-back frames at full throughput: one word per cycle with no bubbles, except the CRC word, which produces no output beat.
- Upstream stalls (tvalid low) at any point: state and CRC are held.
- Reset mid-frame: the partial frame is discarded, no crc_valid is produced, and counters clear.
- crc_ok holds its last value between pulses, but only crc_valid qualifies it.

Decomposition:
- Package axis_crc32_pkg holds:
  - typedef crc32_t (logic [31:0]);
  - constants CRC32_MPEG2_POLY and CRC32_MPEG2_INIT;
  - the function crc32_mpeg2_next(crc, data, poly), which performs the 32-step combinational update. This function is shared with the generator.
  - the state enum {S_DATA, S_CRC}.
- No sub-module. The output register is inline.

Test Plan:
- FRAME_WORDS=1; send 0xFFFF_FFFF then CRC 0x0000_0000 -> m_axis gets 0xFFFF_FFFF with tlast=1; crc_valid pulse with crc_ok=1; frame_cnt=1, err_cnt=0.
- FRAME_WORDS=1; send 0xFFFF_FFFF then 0x0000_0001 -> crc_ok=0; err_cnt=1; the data word is still forwarded.
- FRAME_WORDS=4; 8 back-to-back frames, trailers from the reference model, frame 3 trailer bit-flipped, m_axis_tready=1 -> 32 output beats with tlast every 4th; exactly 8 crc_valid pulses; err_cnt=1; no input bubbles except the CRC word.
- Random m_axis_tready (50%) and random s_axis_tvalid over 100 frames -> output matches input data order; tdata stable during stalls; no lost or duplicated words; frame_cnt=100.
- Reset asserted after 2 of 4 words, then a clean frame -> no crc_valid for the partial frame; the clean frame passes; frame_cnt=1.
- CNT_WIDTH=4; 17 frames -> frame_cnt wraps to 1.
